// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm ringer.
//   alarm_state_t : ringer state encoding
//   bcd_hm_t      : BCD HH:MM payload
//   bcd_time_eq   : HH:MM equality on BCD digits
package alarm_pkg;

  localparam int unsigned CLK_HZ     = 1000;
  localparam int unsigned RING_SEC   = 60;
  localparam int unsigned SNOOZE_SEC = 300;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

  typedef struct packed {
    logic [3:0] h_ten;
    logic [3:0] h_one;
    logic [3:0] m_ten;
    logic [3:0] m_one;
  } bcd_hm_t;

  // True when both HH:MM values carry identical digits.
  function automatic logic bcd_time_eq(input bcd_hm_t a, input bcd_hm_t b);
    return (a == b);
  endfunction

endpackage

// File: rtl/alarm_ringer_if.sv
// Signal bundle between the alarm ringer and its environment.
//   master : drives enable, set strobe, alarm/current time, buttons; sees status
//   slave  : the ringer itself
interface alarm_ringer_if;

  logic       alarm_en;
  logic       alarm_set_done;
  logic [3:0] alarm_h_ten;
  logic [3:0] alarm_h_one;
  logic [3:0] alarm_m_ten;
  logic [3:0] alarm_m_one;
  logic [3:0] cur_h_ten;
  logic [3:0] cur_h_one;
  logic [3:0] cur_m_ten;
  logic [3:0] cur_m_one;
  logic [3:0] cur_s_ten;
  logic [3:0] cur_s_one;
  logic       off_btn;
  logic       snooze_btn;
  logic       alarm_triggered;
  logic       buzzer;
  logic       armed;
  logic       snoozing;

  modport master (
    output alarm_en, alarm_set_done,
    output alarm_h_ten, alarm_h_one, alarm_m_ten, alarm_m_one,
    output cur_h_ten, cur_h_one, cur_m_ten, cur_m_one, cur_s_ten, cur_s_one,
    output off_btn, snooze_btn,
    input  alarm_triggered, buzzer, armed, snoozing
  );

  modport slave (
    input  alarm_en, alarm_set_done,
    input  alarm_h_ten, alarm_h_one, alarm_m_ten, alarm_m_one,
    input  cur_h_ten, cur_h_one, cur_m_ten, cur_m_one, cur_s_ten, cur_s_one,
    input  off_btn, snooze_btn,
    output alarm_triggered, buzzer, armed, snoozing
  );

endinterface

// File: rtl/sec_timer.sv
// Cycle/second counter used for ring and snooze durations.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count enable
//   sec      : whole seconds elapsed since last clear
//   sec_tick : high in the last cycle of each second (combinational)
module sec_timer #(
  parameter int unsigned CLK_HZ = 1000,
  parameter int unsigned SEC_W  = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [SEC_W-1:0] sec,
  output logic             sec_tick
);

  localparam int unsigned CYC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CYC_W-1:0] cyc_q;
  logic [SEC_W-1:0] sec_q;

  assign sec_tick = en && (cyc_q == CYC_W'(CLK_HZ - 1));
  assign sec      = sec_q;

  // Cycle counter wraps at CLK_HZ and carries into the second count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cyc_q <= '0;
      sec_q <= '0;
    end else if (en) begin
      if (sec_tick) begin
        cyc_q <= '0;
        sec_q <= sec_q + SEC_W'(1);
      end else begin
        cyc_q <= cyc_q + CYC_W'(1);
      end
    end
  end

endmodule

// File: rtl/alarm_ringer.sv
// Alarm trigger: arms on set strobe, rings at HH:MM:00, handles snooze/off/timeout.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alarm_ringer_if slave (inputs: enable, set strobe, times, buttons;
//              outputs: alarm_triggered, buzzer, armed, snoozing - all registered)
module alarm_ringer #(
  parameter int unsigned CLK_HZ     = alarm_pkg::CLK_HZ,
  parameter int unsigned RING_SEC   = alarm_pkg::RING_SEC,
  parameter int unsigned SNOOZE_SEC = alarm_pkg::SNOOZE_SEC,
  parameter int unsigned TONE_HALF  = 1
) (
  input  logic           clk,
  input  logic           rst,
  alarm_ringer_if.slave  bus
);

  import alarm_pkg::*;

  localparam int unsigned SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int unsigned SEC_W   = $clog2(SEC_MAX + 1);
  localparam int unsigned TONE_W  = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  alarm_state_t      state_q, state_d;
  logic              hit_q, off_q, snz_q, set_q;
  logic              trig_q, buzzer_q, armed_q, snoozing_q;
  logic [TONE_W-1:0] tone_q;
  bcd_hm_t           alarm_hm_c, cur_hm_c;
  logic              hit_c, trig_c, off_rise_c, snz_rise_c, set_rise_c;
  logic              tmr_clr_c, tmr_en_c, ring_done_c, snz_done_c;
  logic [SEC_W-1:0]  sec_c;
  logic              sec_tick_c;

  // Minute match only at second 00, so a match fires once per minute.
  assign alarm_hm_c = {bus.alarm_h_ten, bus.alarm_h_one, bus.alarm_m_ten, bus.alarm_m_one};
  assign cur_hm_c   = {bus.cur_h_ten, bus.cur_h_one, bus.cur_m_ten, bus.cur_m_one};
  assign hit_c      = bcd_time_eq(alarm_hm_c, cur_hm_c) &&
                      (bus.cur_s_ten == 4'd0) && (bus.cur_s_one == 4'd0);
  assign trig_c     = hit_c & ~hit_q;
  assign off_rise_c = bus.off_btn & ~off_q;
  assign snz_rise_c = bus.snooze_btn & ~snz_q;
  assign set_rise_c = bus.alarm_set_done & ~set_q;

  // Edge history resets high so levels already present at release are not edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= 1'b1;
      off_q <= 1'b1;
      snz_q <= 1'b1;
      set_q <= 1'b1;
    end else begin
      hit_q <= hit_c;
      off_q <= bus.off_btn;
      snz_q <= bus.snooze_btn;
      set_q <= bus.alarm_set_done;
    end
  end

  // Shared timer restarts on any state change and only runs while ringing/snoozing.
  assign tmr_clr_c   = (state_d != state_q);
  assign tmr_en_c    = (state_q == RINGING) || (state_q == SNOOZE);
  assign ring_done_c = sec_tick_c && (sec_c == SEC_W'(RING_SEC - 1));
  assign snz_done_c  = sec_tick_c && (sec_c == SEC_W'(SNOOZE_SEC - 1));

  sec_timer #(
    .CLK_HZ (CLK_HZ),
    .SEC_W  (SEC_W)
  ) u_sec_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr_c),
    .en       (tmr_en_c),
    .sec      (sec_c),
    .sec_tick (sec_tick_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; enable and re-arm override everything else.
  always_comb begin
    state_d = state_q;
    if (!bus.alarm_en) begin
      state_d = IDLE;
    end else if (set_rise_c) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ARMED:   if (trig_c) state_d = RINGING;
        RINGING: begin
          if (off_rise_c)       state_d = ARMED;
          else if (snz_rise_c)  state_d = SNOOZE;
          else if (ring_done_c) state_d = ARMED;
        end
        SNOOZE: begin
          if (off_rise_c)      state_d = ARMED;
          else if (snz_done_c) state_d = RINGING;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered outputs decoded from the next state; tone restarts high on each ring entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q     <= 1'b0;
      armed_q    <= 1'b0;
      snoozing_q <= 1'b0;
      buzzer_q   <= 1'b0;
      tone_q     <= '0;
    end else begin
      trig_q     <= (state_d == RINGING);
      armed_q    <= (state_d != IDLE);
      snoozing_q <= (state_d == SNOOZE);
      if (state_d == RINGING) begin
        if (state_q != RINGING) begin
          tone_q   <= '0;
          buzzer_q <= 1'b1;
        end else if (tone_q == TONE_W'(TONE_HALF - 1)) begin
          tone_q   <= '0;
          buzzer_q <= ~buzzer_q;
        end else begin
          tone_q   <= tone_q + TONE_W'(1);
        end
      end else begin
        tone_q   <= '0;
        buzzer_q <= 1'b0;
      end
    end
  end

  assign bus.alarm_triggered = trig_q;
  assign bus.buzzer          = buzzer_q;
  assign bus.armed           = armed_q;
  assign bus.snoozing        = snoozing_q;

endmodule
